// File: rtl/led_pwm_sciemniacz.sv
// Multi-channel LED dimmer: debounced up/down buttons select a brightness level
// per channel; PWM thresholds fade toward the level's target at period boundaries.
module led_pwm_sciemniacz #(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned COUNTER_WIDTH   = 16,
    parameter int unsigned LEVELS          = 4,
    parameter real         MIN_DUTY        = 0.1,
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned FADE_STEP       = 2048
) (
    input  logic                                                in_clk,
    input  logic                                                in_rst_n,
    input  logic                                                in_przycisk_gora,
    input  logic                                                in_przycisk_dol,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]  in_kanal,
    output logic [CHANNELS-1:0]                                 out_led,
    output logic [$clog2(LEVELS+1)-1:0]                         out_poziom,
    output logic                                                out_okres_koniec
);

    localparam int unsigned W  = COUNTER_WIDTH;
    localparam int unsigned KW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned LW = $clog2(LEVELS + 1);
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [W:0]    FULL     = {1'b1, {W{1'b0}}};
    localparam logic [W:0]    FS       = (FADE_STEP >= (32'd1 << W)) ? FULL : (W+1)'(FADE_STEP);
    localparam bit            FADE_OFF = (FADE_STEP == 0);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    // Geometric duty table entry for level k; top level is forced to fully lit.
    function automatic logic [W:0] thr_calc(input int unsigned k);
        real frac;
        real duty;
        if (k == 0) begin
            return '0;
        end
        if (k >= LEVELS) begin
            return FULL;
        end
        frac = real'(k - 1) / real'(LEVELS - 1);
        duty = MIN_DUTY * ((1.0 / MIN_DUTY) ** frac);
        return (W+1)'($rtoi(duty * real'(FULL) + 0.5));
    endfunction

    logic [W:0] thr_tab [LEVELS+1];

    for (genvar k = 0; k <= LEVELS; k++) begin : g_thr
        localparam logic [W:0] T_K = thr_calc(k);
        assign thr_tab[k] = T_K;
    end

    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_d;
    logic [DW-1:0] deb_cnt [2];
    logic [1:0]    press_c;

    logic [W-1:0]  cnt;
    logic          wrap_c;
    logic [LW-1:0] level [CHANNELS];
    logic [W:0]    act [CHANNELS];
    logic [W:0]    tgt_c [CHANNELS];
    logic [W:0]    dist_c [CHANNELS];
    logic [W:0]    act_next_c [CHANNELS];

    // Button synchroniser and debounce (bit 1 = up, bit 0 = down).
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int b = 0; b < 2; b++) begin
                deb_cnt[b] <= '0;
            end
        end else begin
            sync1 <= {in_przycisk_gora, in_przycisk_dol};
            sync2 <= sync1;
            deb_d <= deb;
            for (int b = 0; b < 2; b++) begin
                if (sync2[b] == deb[b]) begin
                    deb_cnt[b] <= '0;
                end else if (deb_cnt[b] == DB_LAST) begin
                    deb[b]     <= sync2[b];
                    deb_cnt[b] <= '0;
                end else begin
                    deb_cnt[b] <= deb_cnt[b] + DW'(1);
                end
            end
        end
    end

    // Press events are rising edges of the debounced values only.
    always_comb begin
        press_c = deb & ~deb_d;
    end

    // Level of the selected channel; simultaneous up+down cancels out.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                level[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (in_kanal == KW'(i)) begin
                    if (press_c == 2'b10 && level[i] != LW'(LEVELS)) begin
                        level[i] <= level[i] + LW'(1);
                    end else if (press_c == 2'b01 && level[i] != '0) begin
                        level[i] <= level[i] - LW'(1);
                    end
                end
            end
        end
    end

    // Level readback for the selected channel; out-of-range selection reads zero.
    always_comb begin
        out_poziom = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_kanal == KW'(i)) begin
                out_poziom = level[i];
            end
        end
    end

    // Free-running PWM period counter.
    always_comb begin
        wrap_c = &cnt;
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            cnt              <= '0;
            out_okres_koniec <= 1'b0;
        end else begin
            cnt              <= cnt + W'(1);
            out_okres_koniec <= wrap_c;
        end
    end

    // Next active threshold: step toward the level's target, clamping onto it.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            tgt_c[i]      = '0;
            dist_c[i]     = '0;
            act_next_c[i] = act[i];
            for (int k = 0; k <= LEVELS; k++) begin
                if (level[i] == LW'(k)) begin
                    tgt_c[i] = thr_tab[k];
                end
            end
            dist_c[i] = (tgt_c[i] >= act[i]) ? (tgt_c[i] - act[i]) : (act[i] - tgt_c[i]);
            if (FADE_OFF || dist_c[i] <= FS) begin
                act_next_c[i] = tgt_c[i];
            end else if (tgt_c[i] > act[i]) begin
                act_next_c[i] = act[i] + FS;
            end else begin
                act_next_c[i] = act[i] - FS;
            end
        end
    end

    // Thresholds move only on the wrap so a period's duty never changes mid-way.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                act[i] <= '0;
            end
        end else if (wrap_c) begin
            for (int i = 0; i < CHANNELS; i++) begin
                act[i] <= act_next_c[i];
            end
        end
    end

    // Registered PWM compare; threshold 2^W keeps the LED permanently lit.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_led <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                out_led[i] <= ({1'b0, cnt} < act[i]);
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_sciemniacz.sv
// Bench for led_pwm_sciemniacz: two instances (immediate and fading) share stimulus;
// a behavioural model feeds queues that an independent monitor drains.
module tb_led_pwm_sciemniacz;

    localparam int CH   = 5;
    localparam int W    = 8;
    localparam int LV   = 4;
    localparam int DB   = 4;
    localparam int PER  = 256;
    localparam int FS_A = 0;
    localparam int FS_B = 16;

    typedef logic [CH-1:0][8:0] thr_vec_t;
    typedef logic [CH-1:0][2:0] lvl_vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          gora;
    logic          dol;
    logic [2:0]    kanal;
    logic [CH-1:0] led_a;
    logic [CH-1:0] led_b;
    logic [2:0]    poz_a;
    logic [2:0]    poz_b;
    logic          okres_a;
    logic          okres_b;

    led_pwm_sciemniacz #(
        .CHANNELS(CH), .COUNTER_WIDTH(W), .LEVELS(LV), .MIN_DUTY(0.1),
        .DEBOUNCE_CYCLES(DB), .FADE_STEP(FS_A)
    ) dut_a (
        .in_clk(clk), .in_rst_n(rst_n), .in_przycisk_gora(gora), .in_przycisk_dol(dol),
        .in_kanal(kanal), .out_led(led_a), .out_poziom(poz_a), .out_okres_koniec(okres_a)
    );

    led_pwm_sciemniacz #(
        .CHANNELS(CH), .COUNTER_WIDTH(W), .LEVELS(LV), .MIN_DUTY(0.1),
        .DEBOUNCE_CYCLES(DB), .FADE_STEP(FS_B)
    ) dut_b (
        .in_clk(clk), .in_rst_n(rst_n), .in_przycisk_gora(gora), .in_przycisk_dol(dol),
        .in_kanal(kanal), .out_led(led_b), .out_poziom(poz_b), .out_okres_koniec(okres_b)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int       thr [LV+1];
    lvl_vec_t lvl;
    thr_vec_t act_a;
    thr_vec_t act_b;
    bit       hist_g [$];
    bit       hist_d [$];
    bit       deb_g, deb_d, pend_g, pend_d;
    int       edges;
    thr_vec_t exp_a_q [$];
    thr_vec_t exp_b_q [$];
    lvl_vec_t lvl_q [$];

    function automatic int fade_to(input int cur, input int tgt, input int fs);
        if (fs == 0 || (tgt - cur <= fs && cur - tgt <= fs)) return tgt;
        return (tgt > cur) ? cur + fs : cur - fs;
    endfunction

    // True when the DB synchronised samples preceding the newest two all disagree with v.
    function automatic bit all_differ(input bit h [$], input bit v);
        for (int j = 1; j <= DB; j++) begin
            if (h[h.size() - 1 - j] == v) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        lvl    = '0;
        act_a  = '0;
        act_b  = '0;
        deb_g  = 1'b0;
        deb_d  = 1'b0;
        pend_g = 1'b0;
        pend_d = 1'b0;
        edges  = 0;
        hist_g.delete();
        hist_d.delete();
        for (int j = 0; j <= DB; j++) begin
            hist_g.push_back(1'b0);
            hist_d.push_back(1'b0);
        end
        exp_a_q.delete();
        exp_b_q.delete();
        lvl_q.delete();
    endtask

    task automatic model_step();
        bit g;
        bit d;
        int k;
        int l;
        g = gora;
        d = dol;
        k = int'(kanal);
        edges++;
        if (edges % PER == 0) begin
            exp_a_q.push_back(act_a);
            exp_b_q.push_back(act_b);
            for (int i = 0; i < CH; i++) begin
                act_a[i] = 9'(fade_to(int'(act_a[i]), thr[int'(lvl[i])], FS_A));
                act_b[i] = 9'(fade_to(int'(act_b[i]), thr[int'(lvl[i])], FS_B));
            end
        end
        if (pend_g != pend_d && k < CH) begin
            l = int'(lvl[k]);
            if (pend_g) l = (l < LV) ? l + 1 : LV;
            else        l = (l > 0) ? l - 1 : 0;
            lvl[k] = 3'(l);
        end
        pend_g = 1'b0;
        pend_d = 1'b0;
        if (all_differ(hist_g, deb_g)) begin
            deb_g  = !deb_g;
            pend_g = deb_g;
        end
        if (all_differ(hist_d, deb_d)) begin
            deb_d  = !deb_d;
            pend_d = deb_d;
        end
        hist_g.push_back(g);
        hist_d.push_back(d);
        if (hist_g.size() > DB + 2) void'(hist_g.pop_front());
        if (hist_d.size() > DB + 2) void'(hist_d.pop_front());
        lvl_q.push_back(lvl);
    endtask

    initial begin
        for (int k = 0; k <= LV; k++) begin
            if (k == 0)       thr[k] = 0;
            else if (k == LV) thr[k] = PER;
            else              thr[k] = $rtoi(0.1 * (10.0 ** (real'(k - 1) / real'(LV - 1))) * 256.0 + 0.5);
        end
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        int       hi_a [CH];
        int       hi_b [CH];
        int       ws;
        lvl_vec_t snap;
        thr_vec_t ea;
        thr_vec_t eb;
        int       exp_poz;
        ws = 0;
        for (int i = 0; i < CH; i++) begin
            hi_a[i] = 0;
            hi_b[i] = 0;
        end
        forever begin
            @(negedge clk);
            if (!rst_n || edges == 0) begin
                ws = 0;
                for (int i = 0; i < CH; i++) begin
                    hi_a[i] = 0;
                    hi_b[i] = 0;
                end
                continue;
            end
            if (lvl_q.size() == 0) begin
                check("level_queue_empty", 1, 0);
            end else begin
                snap    = lvl_q.pop_front();
                exp_poz = (int'(kanal) < CH) ? int'(snap[int'(kanal)]) : 0;
                check("poziom_a", int'(poz_a), exp_poz);
                check("poziom_b", int'(poz_b), exp_poz);
            end
            check("okres_a", int'(okres_a), int'(edges % PER == 0));
            check("okres_b", int'(okres_b), int'(edges % PER == 0));
            ws++;
            for (int i = 0; i < CH; i++) begin
                hi_a[i] += int'(led_a[i]);
                hi_b[i] += int'(led_b[i]);
            end
            if (okres_a) begin
                check("period_length", ws, PER);
                if (exp_a_q.size() == 0 || exp_b_q.size() == 0) begin
                    check("period_queue_empty", 1, 0);
                end else begin
                    ea = exp_a_q.pop_front();
                    eb = exp_b_q.pop_front();
                    for (int i = 0; i < CH; i++) begin
                        check($sformatf("high_time_a[%0d]", i), hi_a[i], int'(ea[i]));
                        check($sformatf("high_time_b[%0d]", i), hi_b[i], int'(eb[i]));
                    end
                end
                ws = 0;
                for (int i = 0; i < CH; i++) begin
                    hi_a[i] = 0;
                    hi_b[i] = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic drive(input bit g, input bit d, input int k);
        @(posedge clk);
        #2;
        gora  = g;
        dol   = d;
        kanal = 3'(k);
    endtask

    task automatic press(input bit g, input bit d, input int k, input int hold, input int gap);
        drive(g, d, k);
        idle(hold - 1);
        drive(1'b0, 1'b0, k);
        idle(gap - 1);
    endtask

    initial begin
        int  rk;
        bit  rg;
        bit  rd;
        int  rh;
        int  rgap;
        rst_n = 1'b0;
        gora  = 1'b0;
        dol   = 1'b0;
        kanal = '0;
        idle(5);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // idle periods after reset
        idle(3 * PER);

        // short glitch must be rejected, then a real press on channel 0
        press(1'b1, 1'b0, 0, 3, 20);
        press(1'b1, 1'b0, 0, 10, 10);
        idle(2 * PER);

        // saturation up and down
        for (int i = 0; i < 6; i++) press(1'b1, 1'b0, 0, 10, 10);
        idle(2 * PER);
        for (int i = 0; i < 6; i++) press(1'b0, 1'b1, 0, 10, 10);
        idle(18 * PER);

        // fade 0 -> 3, then a down press in the middle of a period
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 0, 10, 10);
        idle(10 * PER);
        idle(PER / 2);
        press(1'b0, 1'b1, 0, 10, 10);
        idle(3 * PER);

        // simultaneous buttons, other channel, out-of-range channel
        press(1'b1, 1'b1, 1, 10, 10);
        press(1'b1, 1'b0, 2, 10, 10);
        press(1'b1, 1'b0, 2, 10, 10);
        press(1'b1, 1'b0, 5, 10, 10);
        press(1'b0, 1'b1, 7, 10, 10);
        idle(2 * PER);

        // randomized presses
        for (int it = 0; it < 40; it++) begin
            rk   = $urandom_range(0, 7);
            rg   = 1'($urandom_range(0, 1));
            rd   = 1'($urandom_range(0, 1));
            rh   = $urandom_range(1, 12);
            rgap = $urandom_range(8, 40);
            if (!rg && !rd) rg = 1'b1;
            press(rg, rd, rk, rh, rgap);
            if (it % 10 == 9) idle(PER);
        end
        idle(2 * PER);

        // asynchronous reset while channel 0 is fully lit
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 0, 10, 10);
        idle(2 * PER);
        @(posedge clk);
        #2;
        check("led_a0_lit_before_reset", int'(led_a[0]), 1);
        rst_n = 1'b0;
        #1;
        check("led_a_async_reset", int'(led_a), 0);
        check("led_b_async_reset", int'(led_b), 0);
        check("poziom_a_async_reset", int'(poz_a), 0);
        check("okres_a_async_reset", int'(okres_a), 0);
        idle(3);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(2 * PER + 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
